fu_mul_sequencer: RTL and testbench

Multi-cycle multiply controller that drives the shared 32-bit function unit through a shift-and-add sequence to form a 64-bit product. Sits beside the function unit in the datapath; while busy it owns the unit's A/B/FS/SH inputs and consumes its F, C, N and V outputs. One multiply takes 32 iteration cycles plus handshake overhead. The host datapath uses `busy` to steer the function-unit input muxes to this block.

---
 rtl/fu_mul_sequencer.sv | 153 +++++++++++++++
 tb/tb_fu_mul_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_mul_sequencer.sv
// Shift-and-add multiply controller that borrows the shared function unit for WIDTH iterations.
// Optional signed support is compiled in with FU_MUL_SIGNED_EN.
module fu_mul_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [4:0]  FS_PASS = 5'b00000,
  parameter logic [4:0]  FS_ADD  = 5'b00010,
  parameter logic [4:0]  FS_SUB  = 5'b00101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef FU_MUL_SIGNED_EN
  input  logic                 op_signed,
`endif
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 prod_zero,
  output logic [WIDTH-1:0]     fu_a,
  output logic [WIDTH-1:0]     fu_b,
  output logic [4:0]           fu_fs,
  output logic [4:0]           fu_sh,
  input  logic [WIDTH-1:0]     fu_f,
  input  logic                 fu_c,
  input  logic                 fu_n,
  input  logic                 fu_v
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  localparam logic [4:0] LastCnt = 5'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     p_q, p_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 zero_q, zero_d;
  logic                 signed_mode;
  logic                 shift_in;
  logic                 last_iter;
  logic [2*WIDTH-1:0]   pq_next;

`ifdef FU_MUL_SIGNED_EN
  logic sgn_q, sgn_d;
  assign signed_mode = sgn_q;
`else
  logic unused_flags;
  assign unused_flags = fu_n ^ fu_v;
  assign signed_mode  = 1'b0;
`endif

  assign last_iter = (cnt_q == LastCnt);

  // Signed mode sign-extends on PASS and uses the true sum sign (N^V) on ADD/SUB.
  always_comb begin
    shift_in = 1'b0;
    if (signed_mode) begin
      shift_in = q_q[0] ? (fu_n ^ fu_v) : p_q[WIDTH-1];
    end else begin
      shift_in = q_q[0] ? fu_c : 1'b0;
    end
  end

  assign pq_next = {shift_in, fu_f, q_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    zero_d  = zero_q;
`ifdef FU_MUL_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    fu_a    = '0;
    fu_b    = '0;
    fu_fs   = FS_PASS;
    fu_sh   = 5'd0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIter;
          m_d     = op_a;
          q_d     = op_b;
          p_d     = '0;
          cnt_d   = 5'd0;
`ifdef FU_MUL_SIGNED_EN
          sgn_d   = op_signed;
`endif
        end
      end
      StIter: begin
        fu_a = p_q;
        fu_b = m_q;
        if (q_q[0]) begin
          fu_fs = (signed_mode && last_iter) ? FS_SUB : FS_ADD;
        end
        {p_d, q_d} = pq_next;
        cnt_d      = cnt_q + 5'd1;
        if (last_iter) begin
          state_d = StDone;
          prod_d  = pq_next;
          zero_d  = (pq_next == '0);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      cnt_q   <= 5'd0;
      prod_q  <= '0;
      zero_q  <= 1'b1;
`ifdef FU_MUL_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      zero_q  <= zero_d;
`ifdef FU_MUL_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign product   = prod_q;
  assign prod_zero = zero_q;

endmodule

// File: tb/tb_fu_mul_sequencer.sv
// Scoreboard bench for fu_mul_sequencer with a behavioural function-unit model.
// Signed cases are exercised when FU_MUL_SIGNED_EN is defined.
module tb_fu_mul_sequencer;

  localparam logic [4:0] FsPass = 5'b00000;
  localparam logic [4:0] FsAdd  = 5'b00010;
  localparam logic [4:0] FsSub  = 5'b00101;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done, prod_zero;
  logic [63:0] product;
  logic [31:0] fu_a, fu_b, fu_f;
  logic [4:0]  fu_fs, fu_sh;
  logic        fu_c, fu_n, fu_v;
`ifdef FU_MUL_SIGNED_EN
  logic        op_signed;
`endif

  fu_mul_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef FU_MUL_SIGNED_EN
    .op_signed (op_signed),
`endif
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .prod_zero (prod_zero),
    .fu_a      (fu_a),
    .fu_b      (fu_b),
    .fu_fs     (fu_fs),
    .fu_sh     (fu_sh),
    .fu_f      (fu_f),
    .fu_c      (fu_c),
    .fu_n      (fu_n),
    .fu_v      (fu_v)
  );

  always #5 clk = ~clk;

  // Combinational function unit
  logic [32:0] fu_sum;
  always_comb begin
    fu_sum = 33'd0;
    fu_v   = 1'b0;
    case (fu_fs)
      FsPass: fu_sum = {1'b0, fu_a};
      FsAdd: begin
        fu_sum = {1'b0, fu_a} + {1'b0, fu_b};
        fu_v   = (fu_a[31] == fu_b[31]) && (fu_sum[31] != fu_a[31]);
      end
      FsSub: begin
        fu_sum = {1'b0, fu_a} + {1'b0, ~fu_b} + 33'd1;
        fu_v   = (fu_a[31] != fu_b[31]) && (fu_sum[31] != fu_a[31]);
      end
      default: fu_sum = 33'd0;
    endcase
    fu_f = fu_sum[31:0];
    fu_c = fu_sum[32];
    fu_n = fu_sum[31];
  end

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input logic ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check(product == e.prod, "product", product, e.prod);
        check(prod_zero == (e.prod == 64'd0), "prod_zero", 64'(prod_zero),
              64'(e.prod == 64'd0));
        check(cyc == e.cyc, "done_latency", 64'(cyc), 64'(e.cyc));
        check(busy == 1'b1, "busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Entry/exit phase for all driving tasks: 1 time unit after a rising edge.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check(1'b0, "wait_idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t e;
    wait_idle();
    op_a  = a;
    op_b  = b;
`ifdef FU_MUL_SIGNED_EN
    op_signed = sgn;
`endif
    start = 1'b1;
    e.prod = ref_mul(a, b, sgn);
    e.cyc  = cyc + 33;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
`ifdef FU_MUL_SIGNED_EN
    op_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    check(done == 1'b0, "rst_done", 64'(done), 64'd0);
    check(product == 64'd0, "rst_product", product, 64'd0);
    check(prod_zero == 1'b1, "rst_prod_zero", 64'(prod_zero), 64'd1);
    check(fu_a == 32'd0, "rst_fu_a", 64'(fu_a), 64'd0);
    check(fu_b == 32'd0, "rst_fu_b", 64'(fu_b), 64'd0);
    check(fu_fs == FsPass, "rst_fu_fs", 64'(fu_fs), 64'(FsPass));
    check(fu_sh == 5'd0, "rst_fu_sh", 64'(fu_sh), 64'd0);
    @(posedge clk); #1;

    issue(32'd3, 32'd5, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(32'd0, 32'h1234_5678, 1'b0);
    drain();

    // Starts at ITER cycle 5 and in the DONE cycle must be ignored
    d0 = done_cnt;
    issue(32'h0000_BEEF, 32'h0000_1234, 1'b0);
    for (int i = 1; i <= 33; i++) begin
      start = (i == 5 || i == 33);
      op_a  = 32'hDEAD_0000;
      op_b  = 32'h0000_0003;
      @(negedge clk);
      check(busy == 1'b1, "busy_held", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check(done_cnt == d0 + 1, "single_done", 64'(done_cnt - d0), 64'd1);

    // Abort at iteration 10
    d0 = done_cnt;
    issue(32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(busy == 1'b0, "abort_busy", 64'(busy), 64'd0);
    check(done == 1'b0, "abort_done", 64'(done), 64'd0);
    check(fu_fs == FsPass, "abort_fu_fs", 64'(fu_fs), 64'(FsPass));
    check(product == 64'd0, "abort_product", product, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check(done_cnt == d0, "abort_no_done", 64'(done_cnt - d0), 64'd0);
    issue(32'd7, 32'd6, 1'b0);
    drain();

    // Function-unit drive follows multiplier bits LSB-first
    issue(32'd5, 32'h0000_000A, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      logic [31:0] mb;
      mb = 32'h0000_000A;
      @(negedge clk);
      check(fu_fs == (mb[i-1] ? FsAdd : FsPass), "fu_fs_seq", 64'(fu_fs),
            64'(mb[i-1] ? FsAdd : FsPass));
      check(fu_sh == 5'd0, "fu_sh_iter", 64'(fu_sh), 64'd0);
      check(fu_b == 32'd5, "fu_b_iter", 64'(fu_b), 64'd5);
      @(posedge clk); #1;
    end
    drain();

    for (int i = 0; i < 20; i++) begin
      issue($urandom, $urandom, 1'b0);
    end
    drain();

`ifdef FU_MUL_SIGNED_EN
    issue(32'hFFFF_FFFD, 32'd5, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(1)));
    end
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
